// File: rtl/game_stat_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_stat_display_pkg
// Description : Game-status encodings, BCD digit type and seven-segment glyphs
//               shared by the game FSM and the status display.
// Revision    : 1.0 - initial release
// ============================================================================
package game_stat_display_pkg;

    typedef enum logic [1:0] {
        CHOSE_BOARD  = 2'b00,
        GAMING       = 2'b01,
        GAME_INITIAL = 2'b10,
        WINNED       = 2'b11
    } game_status_t;

    typedef logic [3:0] bcd_digit_t;

    // Segment order is {dp, g, f, e, d, c, b, a}
    localparam logic [7:0] C_SEG_BLANK = 8'h00;
    localparam logic [7:0] C_SEG_C     = 8'h39;
    localparam logic [7:0] C_SEG_P     = 8'h73;
    localparam logic [7:0] C_SEG_DASH  = 8'h40;
    localparam logic [7:0] C_SEG_D     = 8'h5E;

    function automatic logic [7:0] seg_digit(input bcd_digit_t d);
        logic [7:0] seg;
        case (d)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = C_SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [7:0] seg_phase(input game_status_t s);
        logic [7:0] seg;
        case (s)
            CHOSE_BOARD:  seg = C_SEG_C;
            GAMING:       seg = C_SEG_P;
            GAME_INITIAL: seg = C_SEG_DASH;
            default:      seg = C_SEG_D;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_stat_display_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential 8-bit binary to 3-digit BCD (double-dabble), one
//               shift per cycle, start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import game_stat_display_pkg::*;
(
    input  logic       clk_d,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_bin,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_hundreds,
    output logic [3:0] o_tens,
    output logic [3:0] o_units
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [19:0] r_sr;      // {hundreds, tens, units, binary}
    logic [19:0] w_adj;
    logic [19:0] w_next;

    always_comb begin
        w_adj = r_sr;
        for (int n = 0; n < 3; n++) begin
            if (r_sr[8 + 4*n +: 4] >= 4'd5) begin
                w_adj[8 + 4*n +: 4] = r_sr[8 + 4*n +: 4] + 4'd3;
            end
        end
        w_next = w_adj << 1;
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_sr       <= 20'd0;
            o_done     <= 1'b0;
            o_hundreds <= 4'd0;
            o_tens     <= 4'd0;
            o_units    <= 4'd0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sr    <= {12'd0, i_bin};
                        r_cnt   <= 3'd0;
                        r_state <= S_SHIFT;
                    end
                end
                default: begin
                    r_sr  <= w_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state    <= S_IDLE;
                        o_done     <= 1'b1;
                        o_hundreds <= w_next[19:16];
                        o_tens     <= w_next[15:12];
                        o_units    <= w_next[11:8];
                    end
                end
            endcase
        end
    end

    assign o_busy = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: rtl/game_stat_display.sv
`default_nettype none
// ============================================================================
// Module      : game_stat_display
// Description : Elapsed-time counter, step BCD conversion and 8-digit
//               multiplexed seven-segment driver for the puzzle game.
// Revision    : 1.0 - initial release
// ============================================================================
module game_stat_display
    import game_stat_display_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk_d,
    input  logic       rst,
    input  logic [1:0] game_status,
    input  logic [7:0] step_number,
    output logic [7:0] seg_an,
    output logic [7:0] seg_out
);

    localparam int C_PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int C_SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [C_PRESC_W-1:0] C_PRESC_MAX = C_PRESC_W'(CLK_HZ - 1);
    localparam logic [C_SCAN_W-1:0]  C_SCAN_MAX  = C_SCAN_W'(SCAN_DIV - 1);

    game_status_t w_status;
    assign w_status = game_status_t'(game_status);

    // ---------------- seconds timer ----------------
    logic [C_PRESC_W-1:0] r_presc;
    bcd_digit_t           r_time_h, r_time_t, r_time_u;
    logic                 r_hb;
    logic                 w_tick;
    logic                 w_time_max;

    assign w_tick     = (w_status == GAMING) && (r_presc == C_PRESC_MAX);
    assign w_time_max = (r_time_h == 4'd9) && (r_time_t == 4'd9) && (r_time_u == 4'd9);

    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_presc  <= '0;
            r_time_h <= 4'd0;
            r_time_t <= 4'd0;
            r_time_u <= 4'd0;
            r_hb     <= 1'b0;
        end else begin
            case (w_status)
                GAMING: begin
                    if (w_tick) begin
                        r_presc <= '0;
                        r_hb    <= ~r_hb;
                        if (!w_time_max) begin
                            if (r_time_u != 4'd9) begin
                                r_time_u <= r_time_u + 4'd1;
                            end else begin
                                r_time_u <= 4'd0;
                                if (r_time_t != 4'd9) begin
                                    r_time_t <= r_time_t + 4'd1;
                                end else begin
                                    r_time_t <= 4'd0;
                                    r_time_h <= r_time_h + 4'd1;
                                end
                            end
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                // Final time stays on display after a win
                WINNED: r_hb <= 1'b0;
                default: begin
                    r_presc  <= '0;
                    r_time_h <= 4'd0;
                    r_time_t <= 4'd0;
                    r_time_u <= 4'd0;
                    r_hb     <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- step conversion ----------------
    logic       w_busy, w_done, w_start;
    logic [3:0] w_cv_h, w_cv_t, w_cv_u;
    logic [7:0] r_last;
    bcd_digit_t r_step_h, r_step_t, r_step_u;

    // A change arriving while busy stays pending until the next idle cycle
    assign w_start = !w_busy && (step_number != r_last);

    bin2bcd_seq u_bin2bcd (
        .clk_d      (clk_d),
        .rst        (rst),
        .i_start    (w_start),
        .i_bin      (step_number),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_hundreds (w_cv_h),
        .o_tens     (w_cv_t),
        .o_units    (w_cv_u)
    );

    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_last   <= 8'd0;
            r_step_h <= 4'd0;
            r_step_t <= 4'd0;
            r_step_u <= 4'd0;
        end else begin
            if (w_start) begin
                r_last <= step_number;
            end
            if (w_done) begin
                r_step_h <= w_cv_h;
                r_step_t <= w_cv_t;
                r_step_u <= w_cv_u;
            end
        end
    end

    // ---------------- scan and digit mux ----------------
    logic [C_SCAN_W-1:0] r_scan_cnt;
    logic [2:0]          r_scan_idx;
    logic [7:0]          w_digit_seg;

    always_comb begin
        w_digit_seg = C_SEG_BLANK;
        case (r_scan_idx)
            3'd7: w_digit_seg = (r_step_h == 4'd0) ? C_SEG_BLANK : seg_digit(r_step_h);
            3'd6: w_digit_seg = (r_step_h == 4'd0 && r_step_t == 4'd0) ? C_SEG_BLANK
                                                                        : seg_digit(r_step_t);
            3'd5: w_digit_seg = seg_digit(r_step_u);
            3'd4: w_digit_seg = C_SEG_BLANK;
            3'd3: w_digit_seg = seg_phase(w_status);
            3'd2: w_digit_seg = seg_digit(r_time_h);
            3'd1: w_digit_seg = seg_digit(r_time_t);
            3'd0: w_digit_seg = seg_digit(r_time_u) | {r_hb, 7'd0};
            default: w_digit_seg = C_SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_scan_idx <= 3'd0;
            seg_an     <= 8'd0;
            seg_out    <= 8'd0;
        end else begin
            seg_an  <= 8'd1 << r_scan_idx;
            seg_out <= w_digit_seg;
            if (r_scan_cnt == C_SCAN_MAX) begin
                r_scan_cnt <= '0;
                r_scan_idx <= r_scan_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_stat_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_stat_display
// Description : Self-checking bench for game_stat_display with an integer
//               reference model of timer, step display and scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_stat_display;

    localparam int CLK_HZ   = 10;
    localparam int SCAN_DIV = 2;
    localparam logic [7:0] GLYPH [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                          8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    logic       clk_d = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] game_status = 2'b00;
    logic [7:0] step_number = 8'd0;
    logic [7:0] seg_an, seg_out;

    int n_tests = 0;
    int n_fail  = 0;

    game_stat_display #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV)) dut (
        .clk_d       (clk_d),
        .rst         (rst),
        .game_status (game_status),
        .step_number (step_number),
        .seg_an      (seg_an),
        .seg_out     (seg_out)
    );

    always #5 clk_d = ~clk_d;

    // ---------------- reference model ----------------
    int         m_presc = 0, m_secs = 0, m_idx = 0, m_scnt = 0;
    int         m_last = 0, m_pend = 0, m_disp = 0, m_cnt = 0;
    bit         m_hb = 1'b0;
    logic [7:0] exp_an = 8'd0, exp_out = 8'd0;

    function automatic logic [7:0] m_digit(input int k);
        int h, t, u;
        h = m_disp / 100;
        t = (m_disp / 10) % 10;
        u = m_disp % 10;
        case (k)
            7: return (h == 0) ? 8'h00 : GLYPH[h];
            6: return (h == 0 && t == 0) ? 8'h00 : GLYPH[t];
            5: return GLYPH[u];
            4: return 8'h00;
            3: case (game_status)
                   2'b00:   return 8'h39;
                   2'b01:   return 8'h73;
                   2'b10:   return 8'h40;
                   default: return 8'h5E;
               endcase
            2: return GLYPH[m_secs / 100];
            1: return GLYPH[(m_secs / 10) % 10];
            default: return GLYPH[m_secs % 10] | {m_hb, 7'd0};
        endcase
    endfunction

    always @(posedge clk_d) begin
        if (rst) begin
            m_presc = 0; m_secs = 0; m_idx = 0; m_scnt = 0;
            m_last = 0; m_pend = 0; m_disp = 0; m_cnt = 0; m_hb = 1'b0;
            exp_an = 8'd0; exp_out = 8'd0;
        end else begin
            bit accept;
            exp_an  = 8'd1 << m_idx;
            exp_out = m_digit(m_idx);
            if (m_scnt == SCAN_DIV - 1) begin
                m_scnt = 0;
                m_idx  = (m_idx + 1) % 8;
            end else begin
                m_scnt++;
            end
            case (game_status)
                2'b01: begin
                    if (m_presc == CLK_HZ - 1) begin
                        m_presc = 0;
                        if (m_secs < 999) m_secs++;
                        m_hb = !m_hb;
                    end else begin
                        m_presc++;
                    end
                end
                2'b11: m_hb = 1'b0;
                default: begin m_presc = 0; m_secs = 0; m_hb = 1'b0; end
            endcase
            // result lands 10 edges after the accepting edge's input change
            accept = (m_cnt <= 1) && (int'(step_number) != m_last);
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_disp = m_pend;
            end
            if (accept) begin
                m_last = int'(step_number);
                m_pend = int'(step_number);
                m_cnt  = 9;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cyc_model(input string tag);
        @(negedge clk_d);
        check8({tag, "_an"}, seg_an, exp_an);
        check8({tag, "_out"}, seg_out, exp_out);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc_model(tag);
    endtask

    task automatic read_digit(input int n, output logic [7:0] v);
        logic [7:0] want;
        want = 8'd1 << n;
        v = 8'hxx;
        for (int i = 0; i < 40; i++) begin
            cyc_model("scan");
            if (seg_an === want) begin
                v = seg_out;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $error("FAIL scan_timeout: digit %0d observed an %h expected %h", n, seg_an, want);
    endtask

    task automatic expect_digit(input int n, input logic [7:0] expv, input string tag);
        logic [7:0] v;
        read_digit(n, v);
        check8(tag, v, expv);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] v;
        logic [7:0] prev_an;
        bit         found;

        // 1: reset and first digit
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_d);
            check8("rst_an", seg_an, 8'h00);
            check8("rst_out", seg_out, 8'h00);
        end
        rst = 1'b0;
        @(negedge clk_d);
        check8("first_an", seg_an, 8'h01);
        check8("first_out", seg_out, 8'h3F);
        expect_digit(3, 8'h39, "phase_chose");

        // 2: 35 cycles of GAMING -> 3 seconds
        game_status = 2'b01;
        for (int i = 0; i < 35; i++) begin
            cyc_model("gaming");
            if (seg_an === 8'h08) check8("phase_gaming", seg_out, 8'h73);
        end
        game_status = 2'b11;
        run(1, "win_settle");
        expect_digit(0, 8'h4F, "t3_units");
        expect_digit(1, 8'h3F, "t3_tens");
        expect_digit(2, 8'h3F, "t3_hund");

        // 3: saturation at 999, freeze in WINNED, clear in CHOSE_BOARD
        game_status = 2'b01;
        run(1005 * CLK_HZ, "sat");
        read_digit(0, v);
        check8("sat_units", {1'b0, v[6:0]}, 8'h6F);
        read_digit(1, v);
        check8("sat_tens", v, 8'h6F);
        read_digit(2, v);
        check8("sat_hund", v, 8'h6F);
        game_status = 2'b11;
        run(1, "win_settle");
        expect_digit(0, 8'h6F, "win_units_nodp");
        expect_digit(3, 8'h5E, "phase_winned");
        run(40, "win_hold");
        expect_digit(2, 8'h6F, "win_hund");
        game_status = 2'b00;
        run(1, "chose_settle");
        expect_digit(0, 8'h3F, "clr_units");
        expect_digit(2, 8'h3F, "clr_hund");
        expect_digit(3, 8'h39, "phase_chose2");

        // 4: step 7, exact 10-cycle latency seen on digit 5
        found = 1'b0;
        prev_an = seg_an;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc_model("align");
            if (seg_an === 8'h01 && prev_an !== 8'h01) found = 1'b1;
            prev_an = seg_an;
        end
        n_tests++;
        assert (found) else begin
            n_fail++;
            $error("FAIL align: observed no digit-0 frame start expected one within 40 cycles");
        end
        step_number = 8'd7;
        run(10, "lat");
        check8("lat_an", seg_an, 8'h20);
        check8("lat_before", seg_out, 8'h3F);
        run(1, "lat2");
        check8("lat_after", seg_out, 8'h07);
        expect_digit(6, 8'h00, "s7_tens");
        expect_digit(7, 8'h00, "s7_hund");

        // 5: step 255
        step_number = 8'd255;
        run(12, "s255");
        expect_digit(7, 8'h5B, "s255_hund");
        expect_digit(6, 8'h6D, "s255_tens");
        expect_digit(5, 8'h6D, "s255_units");

        // 6: change while busy, then reset mid-conversion
        step_number = 8'd12;
        run(2, "busy");
        step_number = 8'd140;
        run(25, "busy2");
        expect_digit(7, 8'h06, "s140_hund");
        expect_digit(6, 8'h66, "s140_tens");
        expect_digit(5, 8'h3F, "s140_units");
        step_number = 8'd99;
        run(4, "pre_rst");
        rst = 1'b1;
        step_number = 8'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_d);
            check8("mid_rst_an", seg_an, 8'h00);
            check8("mid_rst_out", seg_out, 8'h00);
        end
        rst = 1'b0;
        expect_digit(7, 8'h00, "rst_hund");
        expect_digit(6, 8'h00, "rst_tens");
        expect_digit(5, 8'h3F, "rst_units");

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) game_status = 2'($urandom_range(0, 3));
            else if ($urandom_range(0, 29) == 0) game_status = 2'b01;
            if ($urandom_range(0, 14) == 0) step_number = 8'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            cyc_model("rand");
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
